// File: rtl/tx_timer.sv
// Transmit-side I2C slave bit sequencer: shifts a byte onto SDA MSB first,
// then releases SDA for the master's ACK/NACK bit and reports the outcome.
module tx_timer #(
    parameter int BYTE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rising_edge_found,
    input  logic                 falling_edge_found,
    input  logic                 start_found,
    input  logic                 stop_found,
    input  logic                 sda_in,
    input  logic                 tx_start,
    input  logic [BYTE_BITS-1:0] tx_data,
    output logic                 sda_out,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 ack_received,
    output logic                 nack_received
);

    localparam int CW = $clog2(BYTE_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_BITS);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RELEASE,
        SAMPLED
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        bit_cnt;
    logic [CW-1:0]        bit_cnt_next;
    logic [BYTE_BITS-1:0] shift_reg;
    logic [BYTE_BITS-1:0] shift_next;
    logic                 ack_bit;
    logic                 ack_bit_next;
    logic                 sda_next;
    logic                 done_next;
    logic                 ack_next;
    logic                 nack_next;
    logic                 abort;
    logic                 rise;
    logic                 fall;

    // A bus START/STOP overrides everything; a rising edge masks a
    // simultaneous (illegal) falling edge.
    assign abort = start_found | stop_found;
    assign rise  = rising_edge_found;
    assign fall  = falling_edge_found & ~rising_edge_found;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (tx_start) state_next = DRIVE;
                DRIVE:   if (fall && bit_cnt == LAST_BIT) state_next = RELEASE;
                RELEASE: if (rise) state_next = SAMPLED;
                SAMPLED: if (fall) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Next values of the registered line driver, counters and pulses.
    always_comb begin
        sda_next     = sda_out;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        ack_bit_next = ack_bit;
        done_next    = 1'b0;
        ack_next     = 1'b0;
        nack_next    = 1'b0;
        if (abort) begin
            sda_next     = 1'b1;
            bit_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift_next   = tx_data;
                        bit_cnt_next = '0;
                        sda_next     = tx_data[BYTE_BITS-1];
                    end
                end
                DRIVE: begin
                    if (rise) begin
                        if (bit_cnt != LAST_BIT) begin
                            bit_cnt_next = bit_cnt + CW'(1);
                        end
                    end else if (fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            sda_next = 1'b1;
                        end else begin
                            shift_next = {shift_reg[BYTE_BITS-2:0], 1'b0};
                            sda_next   = shift_reg[BYTE_BITS-2];
                        end
                    end
                end
                RELEASE: begin
                    sda_next = 1'b1;
                    if (rise) begin
                        ack_bit_next = sda_in;
                    end
                end
                SAMPLED: begin
                    sda_next = 1'b1;
                    if (fall) begin
                        done_next    = 1'b1;
                        ack_next     = ~ack_bit;
                        nack_next    = ack_bit;
                        bit_cnt_next = '0;
                    end
                end
                default: begin
                    sda_next     = 1'b1;
                    bit_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_out       <= 1'b1;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            ack_bit       <= 1'b1;
            tx_done       <= 1'b0;
            ack_received  <= 1'b0;
            nack_received <= 1'b0;
        end else begin
            sda_out       <= sda_next;
            bit_cnt       <= bit_cnt_next;
            shift_reg     <= shift_next;
            ack_bit       <= ack_bit_next;
            tx_done       <= done_next;
            ack_received  <= ack_next;
            nack_received <= nack_next;
        end
    end

endmodule

// File: tb/tb_tx_timer.sv
// Randomised bench for tx_timer: the bench plays the I2C master, reads the
// bits it sees on SDA at each rising edge and compares them to the byte sent.
module tb_tx_timer;

    localparam int BYTE_BITS = 8;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b0;
    logic                 rising_edge_found = 1'b0;
    logic                 falling_edge_found = 1'b0;
    logic                 start_found = 1'b0;
    logic                 stop_found = 1'b0;
    logic                 sda_in = 1'b1;
    logic                 tx_start = 1'b0;
    logic [BYTE_BITS-1:0] tx_data = '0;
    logic                 sda_out;
    logic                 busy;
    logic                 tx_done;
    logic                 ack_received;
    logic                 nack_received;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int done_expected = 0;

    tx_timer #(.BYTE_BITS(BYTE_BITS)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .rising_edge_found (rising_edge_found),
        .falling_edge_found(falling_edge_found),
        .start_found       (start_found),
        .stop_found        (stop_found),
        .sda_in            (sda_in),
        .tx_start          (tx_start),
        .tx_data           (tx_data),
        .sda_out           (sda_out),
        .busy              (busy),
        .tx_done           (tx_done),
        .ack_received      (ack_received),
        .nack_received     (nack_received)
    );

    always #5 clk = ~clk;

    // Counts every cycle tx_done is high, so a stretched or spurious pulse shows up.
    always @(posedge clk) begin
        #1;
        if (tx_done) done_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        total++;
        if (got !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic pulse_edge(input bit r, input bit f);
        rising_edge_found  = r;
        falling_edge_found = f;
        tick();
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
    endtask

    // SCL activity while idle must leave the line released and the block idle.
    task automatic idle_noise();
        repeat ($urandom_range(1, 4)) begin
            sda_in = 1'($urandom);
            pulse_edge(1'($urandom), 1'($urandom));
        end
        sda_in = 1'b1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_sda", sda_out, 1);
    endtask

    // abort_kind: 0 = STOP, 1 = START, 2 = async reset; applied after rise abort_at.
    task automatic applyStimulus(input logic [7:0] data, input bit ack_lvl,
                                 input int abort_at, input int abort_kind,
                                 input int intrude_at, input logic [7:0] intrude_data,
                                 input bit chained);
        logic [7:0] seen;
        bit         both;
        tx_data  = data;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        checkOutput("busy_on", busy, 1);
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            gap();
            seen = {seen[6:0], sda_out};
            checkOutput($sformatf("bit%0d", i), sda_out, data[7-i]);
            both = ($urandom_range(0, 7) == 0);
            pulse_edge(1'b1, both);
            if (abort_at == i + 1) begin
                if (abort_kind == 2) begin
                    #2 n_rst = 1'b0;
                    #1;
                    checkOutput("rst_sda", sda_out, 1);
                    checkOutput("rst_busy", busy, 0);
                    checkOutput("rst_done", tx_done, 0);
                    tick();
                    n_rst = 1'b1;
                end else begin
                    if (abort_kind == 0) stop_found = 1'b1;
                    else start_found = 1'b1;
                    tx_start = 1'b1;
                    tx_data  = ~data;
                    tick();
                    stop_found  = 1'b0;
                    start_found = 1'b0;
                    tx_start    = 1'b0;
                    checkOutput("abort_sda", sda_out, 1);
                    checkOutput("abort_busy", busy, 0);
                end
                checkOutput("abort_no_done", done_seen, done_expected);
                return;
            end
            gap();
            if (intrude_at == i + 1) begin
                tx_data  = intrude_data;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
                checkOutput("busy_hold", busy, 1);
                gap();
            end
            pulse_edge(1'b0, 1'b1);
        end
        checkOutput("byte", seen, data);
        checkOutput("release", sda_out, 1);
        sda_in = ack_lvl;
        gap();
        pulse_edge(1'b1, 1'b0);
        checkOutput("ack_slot_sda", sda_out, 1);
        checkOutput("ack_slot_busy", busy, 1);
        sda_in = 1'b1;
        gap();
        pulse_edge(1'b0, 1'b1);
        done_expected++;
        checkOutput("tx_done", tx_done, 1);
        checkOutput("ack", ack_received, !ack_lvl);
        checkOutput("nack", nack_received, ack_lvl);
        checkOutput("busy_off", busy, 0);
        checkOutput("done_count", done_seen, done_expected);
        if (!chained) begin
            tick();
            checkOutput("done_clear", tx_done, 0);
        end
    endtask

    initial begin
        bit prev_chained;
        repeat (2) tick();
        checkOutput("rst_sda_out", sda_out, 1);
        checkOutput("rst_busy_out", busy, 0);
        checkOutput("rst_tx_done", tx_done, 0);
        checkOutput("rst_ack", ack_received, 0);
        checkOutput("rst_nack", nack_received, 0);
        n_rst = 1'b1;
        tick();

        applyStimulus(8'hA5, 1'b0, 0, 0, 0, 8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1, 0, 0, 0, 8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b0, 4, 0, 0, 8'h00, 1'b0);
        applyStimulus(8'h3C, 1'b0, 0, 0, 0, 8'h00, 1'b0);
        applyStimulus(8'hC3, 1'b0, 0, 0, 5, 8'h11, 1'b1);
        applyStimulus(8'h11, 1'b0, 0, 0, 0, 8'h00, 1'b0);
        applyStimulus(8'hA5, 1'b0, 3, 2, 0, 8'h00, 1'b0);
        applyStimulus(8'h5A, 1'b1, 0, 0, 0, 8'h00, 1'b0);

        prev_chained = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] data;
            bit         ack_lvl;
            int         abort_at;
            int         intrude_at;
            bit         chained;
            data       = 8'($urandom);
            ack_lvl    = 1'($urandom);
            abort_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
            intrude_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            chained    = (abort_at == 0) && ($urandom_range(0, 2) == 0);
            if (!prev_chained) idle_noise();
            applyStimulus(data, ack_lvl, abort_at, int'($urandom_range(0, 2)),
                          intrude_at, 8'($urandom), chained);
            prev_chained = chained;
        end
        repeat (2) tick();
        checkOutput("done_total", done_seen, done_expected);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
